serial_deser: RTL and testbench

//  Serial-in, parallel-out deserializer. It is the receive counterpart of the clocked serial shifter.
//  - Bits arrive one per accepted cycle on sin with a valid/ready handshake.
//  - Bits are assembled LSB-first or MSB-first into an N-bit word.
//  - Each completed word is presented on a registered parallel output with a valid/ready handshake.
//  - Sits between a serial link or shifter output and the ALU operand registers.

---
 rtl/serial_deser.sv | 104 ++++++++++
 tb/tb_serial_deser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser.sv
// Serial-in, parallel-out deserializer: assembles N handshaked bits (MSB- or LSB-first)
// into a word presented on a registered valid/ready output, with a one-word HOLD stage.
module serial_deser #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sin,
    input  logic                 sin_valid,
    output logic                 sin_ready,
    input  logic                 dir,
    input  logic                 clr,
    output logic [N-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [$clog2(N)-1:0] bit_cnt
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;

    logic          accept;
    logic          out_free;
    logic          shift_dir;
    logic [N-1:0]  shifted;

    // Gated by rst_n so nothing looks acceptable while the block is held in reset.
    assign sin_ready  = (state_q == COLLECT) && rst_n;
    assign accept     = sin_valid && sin_ready;
    assign out_free   = !dout_valid_q || dout_ready;
    assign shift_dir  = (cnt_q == '0) ? dir : dir_q;
    assign shifted    = shift_dir ? {sin, sr_q[N-1:1]} : {sr_q[N-2:0], sin};
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_cnt    = cnt_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (clr) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = COLLECT;
        end else if (state_q == HOLD) begin
            if (out_free) begin
                dout_d       = sr_q;
                dout_valid_d = 1'b1;
                sr_d         = '0;
                state_d      = COLLECT;
            end
        end else if (accept) begin
            sr_d = shifted;
            if (cnt_q == '0) begin
                dir_d = dir;
            end
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (out_free) begin
                    dout_d       = shifted;
                    dout_valid_d = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            sr_q         <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end
endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: directed scenarios plus randomized traffic, all checked
// against a word-level model built from bit lists and a pending-word slot.
module tb_serial_deser;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_ready;
    logic         dir = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [1:0]   bit_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_bits[$];
    logic         m_dir = 1'b0;
    logic         m_hold = 1'b0;
    logic [N-1:0] m_hold_word = '0;
    logic [N-1:0] m_out = '0;
    logic         m_out_v = 1'b0;

    serial_deser #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
        .dir(dir), .clr(clr), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] compose(input logic d);
        logic [N-1:0] w = '0;
        for (int i = 0; i < N; i++) begin
            if (m_bits[i] != 0) begin
                if (d) w[i] = 1'b1;
                else   w[N-1-i] = 1'b1;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir = 1'b0; m_hold = 1'b0; m_hold_word = '0; m_out = '0; m_out_v = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic b, input logic d,
                                input logic c, input logic r);
        logic free;
        logic [N-1:0] w;
        free = !m_out_v || r;
        if (m_out_v && r) m_out_v = 1'b0;
        if (c) begin
            m_bits.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (free) begin
                m_out = m_hold_word; m_out_v = 1'b1; m_hold = 1'b0;
            end
        end else if (v) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(int'(b));
            if (m_bits.size() == N) begin
                w = compose(m_dir);
                m_bits.delete();
                if (free) begin
                    m_out = w; m_out_v = 1'b1;
                end else begin
                    m_hold = 1'b1; m_hold_word = w;
                end
            end
        end
    endtask

    task automatic chk_cycle();
        check("dout", 32'(dout), 32'(m_out));
        check("dout_valid", 32'(dout_valid), 32'(m_out_v));
        check("sin_ready", 32'(sin_ready), 32'(!m_hold));
        check("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
    endtask

    task automatic step(input logic v, input logic b, input logic d, input logic c, input logic r);
        sin_valid = v; sin = b; dir = d; clr = c; dout_ready = r;
        @(posedge clk);
        model_update(v, b, d, c, r);
        #1;
        chk_cycle();
    endtask

    task automatic send_word(input logic [N-1:0] bits_msb_first_order, input logic d, input logic r);
        logic [N-1:0] bv = bits_msb_first_order;
        for (int i = N - 1; i >= 0; i--) step(1'b1, bv[i], d, 1'b0, r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sin_valid = 1'b1; sin = 1'b1;
        #1;
        model_reset();
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_cnt", 32'(bit_cnt), 32'd0);
        check("rst_ready", 32'(sin_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_cnt", 32'(bit_cnt), 32'd0);
        sin_valid = 1'b0; sin = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int ready_low;
        do_reset();

        // 1: MSB-first, consumer always ready
        send_word(4'b1011, 1'b0, 1'b1);
        check("t1_dout", 32'(dout), 32'hB);
        check("t1_valid", 32'(dout_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_pulse", 32'(dout_valid), 32'd0);

        // 2: LSB-first, same bit sequence
        send_word(4'b1011, 1'b1, 1'b1);
        check("t2_dout", 32'(dout), 32'hD);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 3: backpressure into HOLD, then release
        send_word(4'b0011, 1'b0, 1'b0);
        send_word(4'b0101, 1'b0, 1'b0);
        check("t3_held", 32'(dout), 32'h3);
        check("t3_ready", 32'(sin_ready), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_dout", 32'(dout), 32'h5);
        check("t3_valid", 32'(dout_valid), 32'd1);
        check("t3_ready2", 32'(sin_ready), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 4: clr aborts a partial word
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t4_cnt", 32'(bit_cnt), 32'd0);
        send_word(4'b0110, 1'b0, 1'b1);
        check("t4_dout", 32'(dout), 32'h6);

        // 5: dir change mid-word ignored
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t5_dout", 32'(dout), 32'h9);

        // 6: reset mid-word
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        send_word(4'b1110, 1'b0, 1'b1);
        check("t6_dout", 32'(dout), 32'hE);

        // 7: back-to-back words
        pulses = 0; ready_low = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < N; i++) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
                if (dout_valid) pulses++;
                if (!sin_ready) ready_low++;
            end
        end
        check("t7_pulses", 32'(pulses), 32'd3);
        check("t7_ready_low", 32'(ready_low), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 2) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
